// File: rtl/ifetch_unit_pkg.sv
// ifetch_unit_pkg: shared types and constants for the instruction fetch unit
package ifetch_unit_pkg;
    typedef enum logic {RUN, DRAIN} fetch_state_t;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC = 32'd4;
    localparam int CNT_W = 3;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular prefetch buffer with flush; DEPTH must be 2 or 4
module fetch_fifo import ifetch_unit_pkg::*; #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;
    assign full = count == DEPTH_C;
    assign empty = count == '0;
    assign do_push = push & ~full & ~flush;
    assign do_pop = pop & ~empty & ~flush;
    assign dout = mem[rd_ptr];
    // storage needs no reset: the head is only observed while count is nonzero
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    // pointers and occupancy; flush empties the buffer in one cycle
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch PC, single-outstanding memory request and prefetch buffer
module ifetch_unit import ifetch_unit_pkg::*; #(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] pc_plus4_f,
    output logic        valid_f
);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    fetch_state_t state;
    logic [31:0] fpc, req_addr;
    logic outstanding, can_start, push, pop, full, empty;
    logic [CNT_W-1:0] count;
    logic [63:0] head;
    // a new request starts from registered state only; no outstanding request means count alone bounds it
    assign can_start = ~rst & ~redirect & ~outstanding & (state == RUN) & (count < DEPTH_C);
    assign imem_req = outstanding | can_start;
    assign imem_addr = outstanding ? req_addr : fpc;
    assign push = imem_ack & imem_req & (state == RUN) & ~redirect;
    assign pop = valid_f & ~stall_f & ~redirect;
    assign valid_f = ~empty;
    assign instr_f = empty ? '0 : head[31:0];
    assign pc_f = empty ? '0 : head[63:32];
    assign pc_plus4_f = empty ? '0 : head[63:32] + PC_INC;
    fetch_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .flush(redirect),
        .din({imem_addr, imem_rdata}),
        .dout(head),
        .full(full),
        .empty(empty),
        .count(count)
    );
    // fetch PC, outstanding-request tracking and RUN/DRAIN sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            fpc <= RESET_PC;
            req_addr <= RESET_PC;
            outstanding <= 1'b0;
        end else begin
            outstanding <= imem_req & ~imem_ack;
            if (can_start) req_addr <= fpc;
            if (redirect) fpc <= redirect_pc & ~32'h3;
            else if (push) fpc <= imem_addr + PC_INC;
            if (state == RUN) state <= (redirect & outstanding & ~imem_ack) ? DRAIN : RUN;
            else state <= imem_ack ? RUN : DRAIN;
        end
    end
    // the request gating makes an ack into a full buffer unreachable
    no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed scenarios plus randomized run against a stream-level reference model
module tb_ifetch_unit;
    localparam int DEPTH = 2;
    logic clk = 1'b0, rst = 1'b1, stall_f = 1'b0, redirect = 1'b0, imem_ack = 1'b0;
    logic [31:0] redirect_pc = '0, imem_rdata = '0;
    logic imem_req, valid_f;
    logic [31:0] imem_addr, instr_f, pc_f, pc_plus4_f;
    int n_cmp = 0, n_fail = 0, lat = 0, wcnt = 0;
    bit lat_rand = 1'b0;
    logic s_req, s_ack, s_valid;
    logic [31:0] s_addr, s_pc, s_instr, s_p4;

    ifetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall_f(stall_f), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_f(instr_f), .pc_f(pc_f), .pc_plus4_f(pc_plus4_f), .valid_f(valid_f)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    // one clock: drive inputs at negedge, answer from the memory model, sample mid-cycle
    task automatic cycle(input logic r, input logic st, input logic rd, input logic [31:0] rpc);
        @(negedge clk);
        rst = r; stall_f = st; redirect = rd; redirect_pc = rpc;
        #1;
        imem_ack = imem_req && (wcnt >= lat);
        imem_rdata = imem_ack ? memfn(imem_addr) : $urandom;
        #1;
        s_req = imem_req; s_addr = imem_addr; s_ack = imem_ack; s_valid = valid_f;
        s_pc = pc_f; s_instr = instr_f; s_p4 = pc_plus4_f;
        @(posedge clk);
        if (r) wcnt = 0;
        else if (s_req) begin
            if (s_ack) begin
                wcnt = 0;
                if (lat_rand) lat = $urandom_range(3, 0);
            end else wcnt++;
        end
    endtask

    task automatic reset_seq();
        wcnt = 0;
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
    endtask

    task automatic test_reset();
        lat = 0; lat_rand = 0;
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
        reset_seq();
        n_cmp++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", s_req); end
        n_cmp++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", s_valid); end
        n_cmp++; if ({s_pc, s_instr, s_p4} !== 96'h0) begin n_fail++; $display("FAIL rst_data got=%h %h %h exp=0", s_pc, s_instr, s_p4); end
        cycle(0, 0, 0, 0);
        n_cmp++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin n_fail++; $display("FAIL rst_first_req got=%b/%h exp=1/0", s_req, s_addr); end
        n_cmp++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL rst_first_valid got=%b exp=0", s_valid); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] e;
        lat = 0; lat_rand = 0;
        reset_seq();
        for (int k = 0; k < 10; k++) begin
            cycle(0, 0, 0, 0);
            n_cmp++; if (s_req !== 1'b1 || s_addr !== 32'(4 * k)) begin n_fail++; $display("FAIL zw_addr k=%0d got=%b/%h exp=1/%h", k, s_req, s_addr, 32'(4 * k)); end
            n_cmp++; if (s_valid !== (k >= 1)) begin n_fail++; $display("FAIL zw_valid k=%0d got=%b exp=%b", k, s_valid, k >= 1); end
            if (k >= 1) begin
                e = 32'(4 * (k - 1));
                n_cmp++; if (s_pc !== e || s_instr !== memfn(e)) begin n_fail++; $display("FAIL zw_head k=%0d got=%h/%h exp=%h/%h", k, s_pc, s_instr, e, memfn(e)); end
                n_cmp++; if (s_p4 !== e + 32'd4) begin n_fail++; $display("FAIL zw_p4 k=%0d got=%h exp=%h", k, s_p4, e + 32'd4); end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] e;
        lat = 0; lat_rand = 0;
        reset_seq();
        for (int k = 0; k < 11; k++) begin
            cycle(0, (k >= 3 && k <= 7), 0, 0);
            if (k >= 4 && k <= 7) begin
                n_cmp++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL stall_req k=%0d got=%b exp=0", k, s_req); end
            end
            if (k >= 3) begin
                e = (k <= 8) ? 32'h8 : 32'(8 + 4 * (k - 8));
                n_cmp++; if (s_valid !== 1'b1 || s_pc !== e) begin n_fail++; $display("FAIL stall_pc k=%0d got=%b/%h exp=1/%h", k, s_valid, s_pc, e); end
            end
        end
    endtask

    task automatic test_redirect_drain();
        logic got_new, got_valid;
        int n;
        lat = 3; lat_rand = 0;
        reset_seq();
        n = 0;
        do begin cycle(0, 0, 0, 0); n++; end while (!(s_req && s_addr == 32'h20 && !s_ack) && n < 200);
        n_cmp++; if (s_req !== 1'b1 || s_addr !== 32'h20 || s_ack !== 1'b0) begin n_fail++; $display("FAIL drain_setup got=%b/%h exp=1/00000020", s_req, s_addr); end
        cycle(0, 0, 1, 32'h0000_0103);
        got_new = 0; got_valid = 0;
        for (int i = 0; i < 40 && !got_valid; i++) begin
            cycle(0, 0, 0, 0);
            if (i == 0) begin
                n_cmp++; if (s_req !== 1'b1 || s_addr !== 32'h20) begin n_fail++; $display("FAIL drain_hold got=%b/%h exp=1/00000020", s_req, s_addr); end
            end
            if (s_req && s_addr !== 32'h20 && !got_new) begin
                got_new = 1;
                n_cmp++; if (s_addr !== 32'h100) begin n_fail++; $display("FAIL drain_next_req got=%h exp=00000100", s_addr); end
            end
            if (s_valid && !got_valid) begin
                got_valid = 1;
                n_cmp++; if (s_pc !== 32'h100) begin n_fail++; $display("FAIL drain_first_pc got=%h exp=00000100", s_pc); end
            end
        end
        n_cmp++; if (!got_valid) begin n_fail++; $display("FAIL drain_timeout got=no_valid exp=valid"); end
    endtask

    task automatic test_redirect_ack();
        logic got_new, got_valid;
        int n;
        lat = 1; lat_rand = 0;
        reset_seq();
        n = 0;
        do begin cycle(0, 0, 0, 0); n++; end while (!(s_req && s_addr == 32'h10 && !s_ack) && n < 200);
        cycle(0, 0, 1, 32'h40);
        n_cmp++; if (s_ack !== 1'b1 || s_addr !== 32'h10) begin n_fail++; $display("FAIL rack_setup got=%b/%h exp=1/00000010", s_ack, s_addr); end
        got_new = 0; got_valid = 0;
        for (int i = 0; i < 30 && !got_valid; i++) begin
            cycle(0, 0, 0, 0);
            if (s_req && !got_new) begin
                got_new = 1;
                n_cmp++; if (s_addr !== 32'h40) begin n_fail++; $display("FAIL rack_next_req got=%h exp=00000040", s_addr); end
            end
            if (s_valid && !got_valid) begin
                got_valid = 1;
                n_cmp++; if (s_pc !== 32'h40) begin n_fail++; $display("FAIL rack_first_pc got=%h exp=00000040", s_pc); end
            end
        end
        n_cmp++; if (!got_valid) begin n_fail++; $display("FAIL rack_timeout got=no_valid exp=valid"); end
    endtask

    task automatic test_back_to_back();
        logic got_new, got_valid;
        int n;
        lat = 3; lat_rand = 0;
        reset_seq();
        n = 0;
        do begin cycle(0, 0, 0, 0); n++; end while (!(s_req && s_addr == 32'h8 && !s_ack) && n < 200);
        cycle(0, 0, 1, 32'h200);
        cycle(0, 0, 1, 32'h300);
        got_new = 0; got_valid = 0;
        for (int i = 0; i < 40 && !got_valid; i++) begin
            cycle(0, 0, 0, 0);
            if (i == 0) begin
                n_cmp++; if (s_req !== 1'b1 || s_addr !== 32'h8) begin n_fail++; $display("FAIL b2b_hold got=%b/%h exp=1/00000008", s_req, s_addr); end
            end
            if (s_req && s_addr !== 32'h8 && !got_new) begin
                got_new = 1;
                n_cmp++; if (s_addr !== 32'h300) begin n_fail++; $display("FAIL b2b_next_req got=%h exp=00000300", s_addr); end
            end
            if (s_valid && !got_valid) begin
                got_valid = 1;
                n_cmp++; if (s_pc !== 32'h300) begin n_fail++; $display("FAIL b2b_first_pc got=%h exp=00000300", s_pc); end
            end
        end
        n_cmp++; if (!got_valid) begin n_fail++; $display("FAIL b2b_timeout got=no_valid exp=valid"); end
    endtask

    task automatic test_wrap();
        logic [31:0] ea, ep;
        lat = 0; lat_rand = 0;
        reset_seq();
        cycle(0, 0, 1, 32'hFFFF_FFFA);
        for (int j = 0; j < 5; j++) begin
            cycle(0, 0, 0, 0);
            ea = 32'hFFFF_FFF8 + 32'(4 * j);
            n_cmp++; if (s_req !== 1'b1 || s_addr !== ea) begin n_fail++; $display("FAIL wrap_addr j=%0d got=%b/%h exp=1/%h", j, s_req, s_addr, ea); end
            if (j >= 1) begin
                ep = 32'hFFFF_FFF8 + 32'(4 * (j - 1));
                n_cmp++; if (s_valid !== 1'b1 || s_pc !== ep || s_p4 !== ep + 32'd4) begin n_fail++; $display("FAIL wrap_head j=%0d got=%b/%h/%h exp=1/%h/%h", j, s_valid, s_pc, s_p4, ep, ep + 32'd4); end
            end
        end
    endtask

    task automatic test_rst_mid();
        lat = 0; lat_rand = 0;
        reset_seq();
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0);
        lat = 3;
        cycle(0, 0, 0, 0);
        n_cmp++; if (s_req !== 1'b1 || s_ack !== 1'b0 || s_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_setup got=%b/%b/%b exp=1/0/1", s_req, s_ack, s_valid); end
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        n_cmp++; if (s_req !== 1'b0 || s_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_clear got=%b/%b exp=0/0", s_req, s_valid); end
        lat = 0;
        cycle(0, 0, 0, 0);
        n_cmp++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin n_fail++; $display("FAIL rstmid_restart got=%b/%h exp=1/0", s_req, s_addr); end
    endtask

    // stream model: consumed pcs run sequentially from the last target, data = memfn(pc)
    task automatic test_random();
        int cnt;
        logic [31:0] exp_pc, exp_fetch, exp_addr, prev_addr, tgt;
        logic stale, prev_req, prev_ack, hold, st, rd, exp_req, consume;
        lat_rand = 1; lat = 0;
        reset_seq();
        cnt = 0; exp_pc = 0; exp_fetch = 0; prev_addr = 0;
        stale = 0; prev_req = 0; prev_ack = 0;
        for (int i = 0; i < 3000; i++) begin
            st = $urandom_range(99, 0) < 30;
            rd = $urandom_range(99, 0) < 7;
            tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : 32'($urandom);
            hold = prev_req & ~prev_ack;
            cycle(0, st, rd, tgt);
            exp_req = hold | (~rd & (cnt < DEPTH));
            exp_addr = (hold & stale) ? prev_addr : exp_fetch;
            n_cmp++; if (s_req !== exp_req) begin n_fail++; $display("FAIL rnd_req i=%0d got=%b exp=%b", i, s_req, exp_req); end
            if (exp_req) begin
                n_cmp++; if (s_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_addr i=%0d got=%h exp=%h", i, s_addr, exp_addr); end
            end
            n_cmp++; if (s_valid !== (cnt > 0)) begin n_fail++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, s_valid, cnt > 0); end
            n_cmp++; if (s_pc !== ((cnt > 0) ? exp_pc : 32'h0)) begin n_fail++; $display("FAIL rnd_pc i=%0d got=%h exp=%h", i, s_pc, (cnt > 0) ? exp_pc : 32'h0); end
            n_cmp++; if (s_instr !== ((cnt > 0) ? memfn(exp_pc) : 32'h0)) begin n_fail++; $display("FAIL rnd_instr i=%0d got=%h exp=%h", i, s_instr, (cnt > 0) ? memfn(exp_pc) : 32'h0); end
            n_cmp++; if (s_p4 !== ((cnt > 0) ? exp_pc + 32'd4 : 32'h0)) begin n_fail++; $display("FAIL rnd_p4 i=%0d got=%h exp=%h", i, s_p4, (cnt > 0) ? exp_pc + 32'd4 : 32'h0); end
            consume = (cnt > 0) & ~st & ~rd;
            if (rd) begin
                cnt = 0;
                exp_pc = tgt & ~32'h3;
                exp_fetch = tgt & ~32'h3;
                stale = exp_req & ~s_ack;
            end else begin
                if (exp_req & s_ack & ~stale) begin cnt++; exp_fetch += 32'd4; end
                if (exp_req & s_ack) stale = 1'b0;
                if (consume) begin cnt--; exp_pc += 32'd4; end
            end
            prev_req = exp_req; prev_ack = s_ack; prev_addr = exp_addr;
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_redirect_drain();
        test_redirect_ack();
        test_back_to_back();
        test_wrap();
        test_rst_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
